multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Sequencing FSM for the multicycle build of the RV32I subset core.
//  Decodes op/funct3/funct7b5 and steps the shared ALU/regfile/memory datapath through
//  fetch, decode, execute and writeback, one step per cycle.
//  Drives datapath enables and mux selects, and counts retired instructions.
// PARAMETERS
//  CNT_W   32   width of retired-instruction counter Instret
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-low reset (0 = reset)
//  op         in   7      Instr[6:0] from instruction register
//  funct3     in   3      Instr[14:12]
//  funct7b5   in   1      Instr[30]
//  Zero       in   1      ALU zero flag
//  MemReady   in   1      memory access complete (used only with MC_MEM_WAIT_EN)
//  PCWrite    out  1      PC register enable
//  AdrSrc     out  1      memory address: 0=PC, 1=Result
//  MemWrite   out  1      data memory write strobe
//  IRWrite    out  1      instruction register / OldPC enable
//  ResultSrc  out  2      00=ALUOut, 01=Data, 10=ALUResult
//  ALUSrcA    out  2      00=PC, 01=OldPC, 10=rs1 (A)
//  ALUSrcB    out  2      00=rs2 (WriteData), 01=ImmExt, 10=const 4
//  RegWrite   out  1      register file write enable
//  ImmSrc     out  2      00=I, 01=S, 10=B, 11=J
//  ALUControl out  3      000 add, 001 sub, 010 and, 011 or, 101 slt
//  Illegal    out  1      sticky: unsupported opcode seen
//  Instret    out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - State reg, 4 bits: FETCH0 DECODE1 MEMADR2 MEMREAD3 MEMWB4 MEMWRITE5 EXECR6 EXECI7
//    ALUWB8 BEQ9 JAL10 TRAP11. Reset (reset==0 at posedge): state=FETCH, Instret=0, Illegal=0.
//  - While reset==0: PCWrite, IRWrite, RegWrite, MemWrite forced 0; other outputs decode FETCH.
//  - Transitions:
//    FETCH->DECODE.
//    DECODE by op: 0000011/0100011->MEMADR; 0110011->EXECR; 0010011->EXECI;
//      1100011->BEQ; 1101111->JAL; any other->TRAP.
//    MEMADR->MEMREAD (lw) or MEMWRITE (sw).
//    MEMREAD->MEMWB.  EXECR/EXECI->ALUWB.
//    MEMWB, MEMWRITE, ALUWB, BEQ, JAL->FETCH.
//    TRAP->TRAP until reset.
//  - Outputs not listed below are 0 (selects 00).
//    FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCWrite=1.
//    DECODE: ALUSrcA=01, ALUSrcB=01 (branch/jump target into ALUOut).
//    MEMADR: ALUSrcA=10, ALUSrcB=01.
//    MEMREAD: AdrSrc=1.
//    MEMWB: ResultSrc=01, RegWrite=1.
//    MEMWRITE: AdrSrc=1, MemWrite=1.
//    EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
//    EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
//    ALUWB: RegWrite=1.
//    BEQ: ALUSrcA=10, ALUOp=01, PCWrite=Zero (Mealy path, same cycle).
//    JAL: ALUSrcA=01, ALUSrcB=10, PCWrite=1.
//    TRAP: all enables 0, Illegal=1.
//  - ALU decode, combinational:
//    ALUOp 00 -> 000; ALUOp 01 -> 001.
//    ALUOp 10, by funct3: 000 -> 001 if (op[5] & funct7b5), else 000; 010 -> 101; 110 -> 011;
//      111 -> 010; other -> 000.
//  - ImmSrc by op: 0100011->01, 1100011->10, 1101111->11, else 00. Held stable in all states.
//  - Instret += 1 on every transition into FETCH from a retiring state. Wraps at 2^CNT_W-1 -> 0.
//  - Latency, no waits: R/I = 4 cycles, lw = 5, sw = 4, beq = 3, jal = 3.
//  - Reset mid-instruction: effective at the next posedge; partial writes abandoned.
// CONFIGURATION
//  MC_MEM_WAIT_EN defined: FETCH, MEMREAD and MEMWRITE hold while MemReady==0.
//    FETCH hold cycles: IRWrite=PCWrite=0.
//    MEMWRITE hold cycles: MemWrite stays 1.
//    The state advances and enables fire only in the cycle where MemReady==1.
//  MC_MEM_WAIT_EN undefined: MemReady ignored; each memory state lasts exactly 1 cycle.
// TESTING
//  1 Reset low 2 cycles, release -> state FETCH, Instret=0, Illegal=0; no write enable during reset.
//  2 op=0110011, funct3=000, funct7b5=1 (sub) -> FETCH,DECODE,EXECR,ALUWB,FETCH.
//    ALUControl=001 in EXECR; RegWrite=1 only in ALUWB; Instret 0->1.
//  3 lw (op=0000011) -> 5-cycle sequence; ImmSrc=00; ResultSrc=01 + RegWrite in MEMWB.
//    sw (op=0100011) -> MemWrite=1 exactly 1 cycle; ImmSrc=01.
//  4 beq, Zero=1 -> PCWrite=1 in BEQ, ALUControl=001. Zero=0 -> PCWrite=0. Both retire (Instret+1).
//  5 op=1111111 -> TRAP after DECODE; Illegal=1, no enables, held 20 cycles; reset clears it.
//  6 MC_MEM_WAIT_EN: MemReady=0 for 3 cycles in MEMWRITE -> 4 cycles in MEMWRITE, MemWrite held,
//    then FETCH. Reset low during MEMWRITE -> MemWrite=0 same cycle, FETCH next.

Source files
------------

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I subset core: decode, datapath enables/selects, retire counter.
// Optional MC_MEM_WAIT_EN: FETCH/MEMREAD/MEMWRITE hold until MemReady; otherwise MemReady is ignored.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegWrite,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             Illegal,
    output logic [CNT_W-1:0] Instret
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECR    = 4'd6;
    localparam logic [3:0] EXECI    = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BEQ      = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;
    localparam logic [3:0] TRAP     = 4'd11;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    logic [3:0]       state_reg;
    logic [3:0]       state_next;
    logic [3:0]       state_eff;
    logic [CNT_W-1:0] instret_reg;
    logic             illegal_reg;
    logic [1:0]       alu_op;
    logic             mem_go;
    logic             retire;

`ifdef MC_MEM_WAIT_EN
    assign mem_go = MemReady;
`else
    logic unused_memready;
    assign unused_memready = MemReady;
    assign mem_go          = 1'b1;
`endif

    // While held in reset the outputs decode as FETCH (with enables masked below).
    assign state_eff = reset ? state_reg : FETCH;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH:    if (mem_go) state_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECR;
                    OP_I:         state_next = EXECI;
                    OP_BEQ:       state_next = BEQ;
                    OP_JAL:       state_next = JAL;
                    default:      state_next = TRAP;
                endcase
            end
            MEMADR:   state_next = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (mem_go) state_next = MEMWB;
            MEMWRITE: if (mem_go) state_next = FETCH;
            EXECR, EXECI: state_next = ALUWB;
            MEMWB, ALUWB, BEQ, JAL: state_next = FETCH;
            TRAP:     state_next = TRAP;
            default:  state_next = FETCH;
        endcase
    end

    always_comb begin
        retire = 1'b0;
        case (state_reg)
            MEMWB, ALUWB, BEQ, JAL: retire = 1'b1;
            MEMWRITE:               retire = mem_go;
            default:                retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= FETCH;
            instret_reg <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (retire) begin
                instret_reg <= instret_reg + CNT_W'(1);
            end
            if (state_next == TRAP) begin
                illegal_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        RegWrite  = 1'b0;
        alu_op    = 2'b00;
        case (state_eff)
            FETCH: begin
                IRWrite   = mem_go;
                PCWrite   = mem_go;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            // The strobe stays up across memory wait cycles.
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b00;
                alu_op  = 2'b10;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            ALUWB:    RegWrite = 1'b1;
            BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                PCWrite = Zero;
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
        if (!reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

    always_comb begin
        case (alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            default: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign Illegal = reset & illegal_reg;
    assign Instret = instret_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-instruction phase model feeds a queue, a negedge monitor compares.
// Honours MC_MEM_WAIT_EN when defined, so the same bench covers both builds.
module tb_multicycle_controller;

    localparam int CW = 4;

`ifdef MC_MEM_WAIT_EN
    localparam bit WAIT_MODE = 1'b1;
`else
    localparam bit WAIT_MODE = 1'b0;
`endif

    typedef struct packed {
        logic          pcw;
        logic          adr;
        logic          mw;
        logic          irw;
        logic [1:0]    rs;
        logic [1:0]    sa;
        logic [1:0]    sb;
        logic          rw;
        logic [1:0]    imm;
        logic [2:0]    alu;
        logic          ill;
        logic [CW-1:0] ir;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [6:0]    op = 7'b0110011;
    logic [2:0]    funct3 = 3'b000;
    logic          funct7b5 = 1'b0;
    logic          Zero = 1'b0;
    logic          MemReady = 1'b1;
    logic          PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]    ALUControl;
    logic [CW-1:0] Instret;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  mon_exp, mon_got;
    string mon_name;
    int    errors = 0;
    int    checks = 0;
    int    retired = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .Illegal(Illegal), .Instret(Instret)
    );

    function automatic logic [6:0] op_of(input int cls);
        logic [6:0] bad [4];
        bad = '{7'b1111111, 7'b0110111, 7'b0000000, 7'b1100111};
        case (cls)
            0: return 7'b0110011;
            1: return 7'b0010011;
            2: return 7'b0000011;
            3: return 7'b0100011;
            4: return 7'b1100011;
            5: return 7'b1101111;
            default: return bad[$urandom_range(0, 3)];
        endcase
    endfunction

    function automatic int len_of(input int cls);
        if (cls == 6) return 22;
        if (cls == 2) return 5;
        if (cls >= 4) return 3;
        return 4;
    endfunction

    function automatic string phase_of(input int cls, input int i);
        if (i == 0) return "FETCH";
        if (i == 1) return "DECODE";
        if (cls == 0) begin if (i == 2) return "EXECR"; return "ALUWB"; end
        if (cls == 1) begin if (i == 2) return "EXECI"; return "ALUWB"; end
        if (cls == 2) begin
            if (i == 2) return "MEMADR";
            if (i == 3) return "MEMREAD";
            return "MEMWB";
        end
        if (cls == 3) begin if (i == 2) return "MEMADR"; return "MEMWRITE"; end
        if (cls == 4) return "BEQ";
        if (cls == 5) return "JAL";
        return "TRAP";
    endfunction

    // ALU operation named by the instruction: add/sub/slt/or/and.
    function automatic logic [2:0] alu_expect();
        if (funct3 == 3'b000) return (op == 7'b0110011 && funct7b5) ? 3'b001 : 3'b000;
        if (funct3 == 3'b010) return 3'b101;
        if (funct3 == 3'b110) return 3'b011;
        if (funct3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    function automatic exp_t model(input string ph, input logic rst_n, input logic stall, input logic z);
        exp_t  e;
        string p;
        e = '0;
        p = ph;
        if (!rst_n) p = "FETCH";
        if (op == 7'b0100011)      e.imm = 2'b01;
        else if (op == 7'b1100011) e.imm = 2'b10;
        else if (op == 7'b1101111) e.imm = 2'b11;
        e.ir = retired[CW-1:0];
        if (p == "FETCH")    begin e.irw = ~stall; e.pcw = ~stall; e.sb = 2'b10; e.rs = 2'b10; end
        if (p == "DECODE")   begin e.sa = 2'b01; e.sb = 2'b01; end
        if (p == "MEMADR")   begin e.sa = 2'b10; e.sb = 2'b01; end
        if (p == "MEMREAD")  e.adr = 1'b1;
        if (p == "MEMWB")    begin e.rs = 2'b01; e.rw = 1'b1; end
        if (p == "MEMWRITE") begin e.adr = 1'b1; e.mw = 1'b1; end
        if (p == "EXECR")    begin e.sa = 2'b10; e.alu = alu_expect(); end
        if (p == "EXECI")    begin e.sa = 2'b10; e.sb = 2'b01; e.alu = alu_expect(); end
        if (p == "ALUWB")    e.rw = 1'b1;
        if (p == "BEQ")      begin e.sa = 2'b10; e.alu = 3'b001; e.pcw = z; end
        if (p == "JAL")      begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
        if (p == "TRAP")     e.ill = 1'b1;
        if (!rst_n) begin e.pcw = 1'b0; e.irw = 1'b0; e.rw = 1'b0; e.mw = 1'b0; end
        return e;
    endfunction

    task automatic tick(input exp_t e, input string nm, input logic rst, input logic mr, input logic z);
        reset    = rst;
        MemReady = mr;
        Zero     = z;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string nm, input logic ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s: PCWrite=%b IRWrite=%b RegWrite=%b MemWrite=%b Illegal=%b Instret=%0d",
                     nm, PCWrite, IRWrite, RegWrite, MemWrite, Illegal, Instret);
        end else begin
            $display("PASS %s", nm);
        end
    endtask

    // hold >= 0 forces that many MemReady=0 cycles in each memory phase; -1 randomises (bounded).
    task automatic run_insn(input int cls, input logic [2:0] f3, input logic f7,
                            input int zsel, input int abort_at, input int hold);
        int    len, k;
        string ph;
        logic  z, mr, stall, memph;
        len      = len_of(cls);
        op       = op_of(cls);
        funct3   = f3;
        funct7b5 = f7;
        $display("insn cls=%0d op=%b funct3=%b funct7b5=%b abort_at=%0d retired_before=%0d",
                 cls, op, f3, f7, abort_at, retired);
        for (int i = 0; i < len; i++) begin
            ph = phase_of(cls, i);
            z  = (zsel < 0) ? 1'($urandom_range(0, 1)) : zsel[0];
            if (i == abort_at) begin
                tick(model(ph, 1'b0, 1'b0, z), {"reset_in_", ph}, 1'b0, 1'($urandom_range(0, 1)), z);
                retired = 0;
                return;
            end
            memph = (ph == "FETCH") || (ph == "MEMREAD") || (ph == "MEMWRITE");
            k = 0;
            do begin
                if (hold >= 0) mr = (k >= hold);
                else           mr = (k >= 5) || ($urandom_range(0, 9) < 6);
                stall = WAIT_MODE && memph && !mr;
                tick(model(ph, 1'b1, stall, z), ph, 1'b1, mr, z);
                k++;
            end while (stall);
        end
        if (cls == 6) begin
            tick(model("TRAP", 1'b0, 1'b0, 1'b0), "reset_after_trap", 1'b0, 1'b1, 1'b0);
            retired = 0;
        end else begin
            retired = (retired + 1) % (1 << CW);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_got  = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                        RegWrite, ImmSrc, ALUControl, Illegal, Instret};
            checks++;
            if (mon_got !== mon_exp) begin
                errors++;
                $display("FAIL %s: got %b required %b (pcw adr mw irw rs sa sb rw imm alu ill instret)",
                         mon_name, mon_got, mon_exp);
            end
        end
    end

    initial begin
        int cls, ab;
        @(posedge clk);
        #1;
        tick(model("FETCH", 1'b0, 1'b0, 1'b0), "reset", 1'b0, 1'b1, 1'b0);
        check_now("reset_state",
                  (Instret == '0) && (Illegal == 1'b0) && (PCWrite == 1'b0) &&
                  (IRWrite == 1'b0) && (RegWrite == 1'b0) && (MemWrite == 1'b0));

        run_insn(0, 3'b000, 1'b1, -1, -1, 0);   // sub
        run_insn(2, 3'b010, 1'b0, -1, -1, 0);   // lw
        run_insn(3, 3'b010, 1'b0, -1, -1, 0);   // sw
        run_insn(4, 3'b000, 1'b0, 1, -1, 0);    // beq taken
        run_insn(4, 3'b000, 1'b0, 0, -1, 0);    // beq not taken
        run_insn(1, 3'b000, 1'b1, -1, -1, 0);   // addi: funct7b5 must not turn it into sub
        run_insn(0, 3'b010, 1'b0, -1, -1, 0);   // slt
        run_insn(0, 3'b110, 1'b0, -1, -1, 0);   // or
        run_insn(0, 3'b111, 1'b0, -1, -1, 0);   // and
        run_insn(0, 3'b001, 1'b0, -1, -1, 0);   // unsupported funct3 -> add
        run_insn(5, 3'b000, 1'b0, -1, -1, 0);   // jal
        run_insn(6, 3'b000, 1'b0, -1, -1, 0);   // illegal, trap, reset
        run_insn(3, 3'b010, 1'b0, -1, -1, 3);   // sw with 3 MemReady-low cycles
        check_now("wait_expired_back_in_fetch",
                  (MemWrite == 1'b0) && (IRWrite == 1'b1) && (PCWrite == 1'b1) &&
                  (Instret == retired[CW-1:0]));
        run_insn(0, 3'b000, 1'b0, -1, -1, 0);
        run_insn(3, 3'b010, 1'b0, -1, 3, 0);    // reset during MEMWRITE

        for (int n = 0; n < 80; n++) begin
            cls = $urandom_range(0, 12);
            if (cls > 6) cls = cls - 6;
            if (cls == 6 && $urandom_range(0, 2) != 0) cls = 0;
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len_of(cls) - 1) : -1;
            run_insn(cls, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, ab, -1);
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
